yes_no_dialog_ctrl: RTL and testbench
=====================================

Name: yes_no_dialog_ctrl

Overview:
Sequences the YES/NO touch-button hit detector for an on-screen confirmation dialog.
- Opens the dialog on request and enables the detector.
- Debounces a press on one button, waits for release, then reports a single answer or a timeout.
- Sits between the UI/counter control logic and the hit detector, which sees the same gr_x/gr_y bus and returns hit_yes/hit_no with 1-cycle latency.

Parameters:
CNT_W, 32, width of hold and timeout counters
HOLD_CYCLES, 32'd50000, consecutive cycles a press must stay on one button to count as valid (>=1)
TIMEOUT_CYCLES, 32'd250000000, cycles from dialog open until auto-timeout; 0 disables timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
dialog_req  in  1  single-cycle request to open the dialog
dialog_cancel  in  1  abort the open dialog; no answer is produced
touch_valid  in  1  touch panel currently pressed (gr_x/gr_y valid)
hit_yes  in  1  detector: last-cycle coordinates inside the YES box
hit_no  in  1  detector: last-cycle coordinates inside the NO box
det_enable  out  1  enable to the hit detector
dialog_active  out  1  draw the dialog; high in every state except IDLE
answer_valid  out  1  1-cycle pulse when the dialog closes with a result
answer_yes  out  1  result; valid with answer_valid, held until the next answer
answer_timeout  out  1  result was a timeout; valid with answer_valid, held

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - All outputs 0.
  - Counters 0.
  - cand=0.
  - mask=1.
- All outputs are registered.
- States: IDLE, ARM, WAIT_PRESS, HOLD, WAIT_RELEASE, DONE.
- IDLE:
  - det_enable=0.
  - dialog_req=1 -> ARM; clear timeout counter; set mask.
  - dialog_req is ignored in all other states.
- det_enable=1 in ARM, WAIT_PRESS, HOLD, WAIT_RELEASE.
- mask: the first cycle after det_enable rises, hit_* are treated as 0 (detector latency). mask clears after that cycle.
- ARM: waits for touch_valid=0, so a press carried over from before the dialog cannot answer it. Then -> WAIT_PRESS.
- Effective hit:
  - yes = hit_yes & ~hit_no & touch_valid & ~mask.
  - no = hit_no & ~hit_yes & touch_valid & ~mask.
  - Both hits high counts as no hit.
- WAIT_PRESS: on an effective hit, latch cand (1=yes, 0=no), set hold_cnt=1, -> HOLD.
- HOLD:
  - Effective hit on the same button: hold_cnt++.
  - Reaching HOLD_CYCLES -> WAIT_RELEASE.
  - Any other input (release, slide off, other button) -> WAIT_PRESS, hold_cnt=0.
  - HOLD_CYCLES=1 means WAIT_PRESS goes straight to WAIT_RELEASE.
- WAIT_RELEASE:
  - touch_valid=0 -> DONE.
  - Sliding off the button here does not cancel the answer.
  - The timeout is frozen here.
- DONE, one cycle:
  - answer_valid=1, answer_yes=cand, answer_timeout=0.
  - -> IDLE.
  - dialog_active drops in the same cycle as the IDLE entry.
- Timeout:
  - Counter runs in ARM/WAIT_PRESS/HOLD.
  - When it reaches TIMEOUT_CYCLES-1, the next cycle is a DONE-equivalent pulse with answer_timeout=1, answer_yes=0.
  - Timeout beats a hold completing in the same cycle.
- dialog_cancel: in any non-IDLE state -> IDLE next cycle. No answer_valid. answer_* unchanged. Cancel has priority over timeout and DONE.
- Counters saturate; no wrap-around.

Decomposition:
- Shared package holds:
  - State encoding typedef (6 states, 3 bits).
  - Default HOLD/TIMEOUT constants, so the UI top and the bench agree.
- One natural sub-module: dialog_timer (CNT_W counter with clear, run, and terminal-count flag), used for both the hold and timeout counters.
- The FSM, mask and result registers stay in the top level.

Test Plan:
HOLD_CYCLES=4 and TIMEOUT_CYCLES=20 unless noted.
1. Normal YES: reset low 3 cycles, then dialog_req pulse; touch_valid=1 with hit_yes=1 for 5 cycles, then release -> answer_valid single pulse 1 cycle after release, answer_yes=1, answer_timeout=0, det_enable 0 after.
2. Carry-over and bounce: touch_valid=1 already at dialog_req -> stays ARM. Release, press NO for 2 cycles, lift, press NO for 4 cycles, release -> answer_yes=0, exactly one answer_valid.
3. Slide: hit_yes for 3 cycles then hit_no for 4 cycles, release -> answer_yes=0; hold restarted on the NO button.
4. Timeout: dialog_req with no touch -> answer_valid with answer_timeout=1 exactly 21 cycles after req. With TIMEOUT_CYCLES=0, no answer after 1000 cycles.
5. Cancel and reset: dialog_cancel during HOLD -> IDLE, no answer_valid, previous answer_yes kept. Reset asserted in WAIT_RELEASE -> all outputs 0 immediately (asynchronous).
6. Overlap/mask: hit_yes=hit_no=1 for 10 cycles -> no answer. hit_yes=1 on the first det_enable cycle only -> ignored.

Source files
------------

// File: rtl/yes_no_dialog_ctrl_pkg.sv
// Shared types and default timing constants for the YES/NO confirmation dialog.
// The UI top and the bench both pull these in so they agree on encodings.
package yes_no_dialog_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ARM          = 3'd1,
    S_WAIT_PRESS   = 3'd2,
    S_HOLD         = 3'd3,
    S_WAIT_RELEASE = 3'd4,
    S_DONE         = 3'd5
  } dialog_state_t;

  localparam int          DEF_CNT_W          = 32;
  localparam logic [31:0] DEF_HOLD_CYCLES    = 32'd50000;
  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd250000000;

endpackage

// File: rtl/yes_no_dialog_ctrl_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
// Serves both the press-hold counter and the dialog timeout counter.
module dialog_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] terminal,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Clear wins over run; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == terminal);

endmodule

// File: rtl/yes_no_dialog_ctrl.sv
// Confirmation dialog sequencer: arms the YES/NO hit detector, debounces one
// button press, waits for release and reports a single answer or a timeout.
module yes_no_dialog_ctrl
  import yes_no_dialog_ctrl_pkg::*;
#(
  parameter int               CNT_W          = DEF_CNT_W,
  parameter logic [CNT_W-1:0] HOLD_CYCLES    = CNT_W'(DEF_HOLD_CYCLES),
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = CNT_W'(DEF_TIMEOUT_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dialog_req,
  input  logic          dialog_cancel,
  input  logic          touch_valid,
  input  logic          hit_yes,
  input  logic          hit_no,
  output logic          det_enable,
  output logic          dialog_active,
  output logic          answer_valid,
  output logic          answer_yes,
  output logic          answer_timeout,
  output dialog_state_t dbg_state
);

  localparam logic [CNT_W-1:0] HOLD_TERM    = HOLD_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = TIMEOUT_CYCLES - CNT_W'(1);
  localparam logic             TIMEOUT_EN   = (TIMEOUT_CYCLES != '0);

  dialog_state_t state, next_state;
  logic mask, cand;
  logic eff_yes, eff_no, eff_hit, eff_same;
  logic timing, hold_run, hold_tc, tout_tc, timeout_hit;
  logic det_enable_d, dialog_active_d, answer_valid_d, answer_yes_d, answer_timeout_d;

  // Both boxes lit at once is ambiguous and treated as no hit at all.
  assign eff_yes  = hit_yes & ~hit_no & touch_valid & ~mask;
  assign eff_no   = hit_no & ~hit_yes & touch_valid & ~mask;
  assign eff_hit  = eff_yes | eff_no;
  assign eff_same = cand ? eff_yes : eff_no;

  assign timing      = (state == S_ARM) || (state == S_WAIT_PRESS) || (state == S_HOLD);
  assign timeout_hit = TIMEOUT_EN && timing && tout_tc;
  assign hold_run    = ((state == S_WAIT_PRESS) && eff_hit) || ((state == S_HOLD) && eff_same);

  // tc is checked on the pre-increment value, so a hit with tc set completes the hold.
  dialog_timer #(.CNT_W(CNT_W)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (~hold_run),
    .run      (hold_run),
    .terminal (HOLD_TERM),
    .tc       (hold_tc)
  );

  dialog_timer #(.CNT_W(CNT_W)) u_timeout_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == S_IDLE),
    .run      (timing),
    .terminal (TIMEOUT_TERM),
    .tc       (tout_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:         if (dialog_req) next_state = S_ARM;
      S_ARM:          if (!touch_valid) next_state = S_WAIT_PRESS;
      S_WAIT_PRESS:   if (hold_run) next_state = hold_tc ? S_WAIT_RELEASE : S_HOLD;
      S_HOLD:         next_state = !hold_run ? S_WAIT_PRESS : (hold_tc ? S_WAIT_RELEASE : S_HOLD);
      S_WAIT_RELEASE: if (!touch_valid) next_state = S_DONE;
      S_DONE:         next_state = S_IDLE;
      default:        next_state = S_IDLE;
    endcase
    if (timeout_hit) next_state = S_DONE;
    if (dialog_cancel && (state != S_IDLE)) next_state = S_IDLE;
  end

  // Results are captured on DONE entry; only WAIT_RELEASE reaches DONE without a timeout.
  always_comb begin
    det_enable_d     = (next_state == S_ARM) || (next_state == S_WAIT_PRESS) ||
                       (next_state == S_HOLD) || (next_state == S_WAIT_RELEASE);
    dialog_active_d  = (next_state != S_IDLE);
    answer_valid_d   = (next_state == S_DONE);
    answer_yes_d     = answer_yes;
    answer_timeout_d = answer_timeout;
    if (answer_valid_d) begin
      answer_yes_d     = (state == S_WAIT_RELEASE) ? cand : 1'b0;
      answer_timeout_d = (state != S_WAIT_RELEASE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_enable     <= 1'b0;
      dialog_active  <= 1'b0;
      answer_valid   <= 1'b0;
      answer_yes     <= 1'b0;
      answer_timeout <= 1'b0;
      cand           <= 1'b0;
      mask           <= 1'b1;
    end else begin
      det_enable     <= det_enable_d;
      dialog_active  <= dialog_active_d;
      answer_valid   <= answer_valid_d;
      answer_yes     <= answer_yes_d;
      answer_timeout <= answer_timeout_d;
      // Detector output lags one cycle, so the first enabled cycle is blanked.
      mask           <= (state == S_IDLE);
      if ((state == S_WAIT_PRESS) && hold_run) cand <= eff_yes;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_yes_no_dialog_ctrl.sv
// Directed bench for yes_no_dialog_ctrl: a vector table for single-cycle
// behaviour plus hand sequences for timeout, cancel, async reset and no-timeout.
module tb_yes_no_dialog_ctrl;
  import yes_no_dialog_ctrl_pkg::*;

  localparam int          CNT_W = 32;
  localparam logic [31:0] HOLD  = 32'd4;
  localparam logic [31:0] TOUT  = 32'd20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic dialog_req = 0, dialog_cancel = 0, touch_valid = 0, hit_yes = 0, hit_no = 0;
  logic det_enable, dialog_active, answer_valid, answer_yes, answer_timeout;
  dialog_state_t dbg_state;

  logic req2 = 0, zero2 = 0;
  logic det_enable2, dialog_active2, answer_valid2, answer_yes2, answer_timeout2;
  dialog_state_t dbg_state2;

  yes_no_dialog_ctrl #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .dialog_req(dialog_req), .dialog_cancel(dialog_cancel),
    .touch_valid(touch_valid), .hit_yes(hit_yes), .hit_no(hit_no),
    .det_enable(det_enable), .dialog_active(dialog_active), .answer_valid(answer_valid),
    .answer_yes(answer_yes), .answer_timeout(answer_timeout), .dbg_state(dbg_state)
  );

  yes_no_dialog_ctrl #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(32'd0)) dut_nt (
    .clk(clk), .reset(reset), .dialog_req(req2), .dialog_cancel(zero2),
    .touch_valid(zero2), .hit_yes(zero2), .hit_no(zero2),
    .det_enable(det_enable2), .dialog_active(dialog_active2), .answer_valid(answer_valid2),
    .answer_yes(answer_yes2), .answer_timeout(answer_timeout2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // in = {req, cancel, touch, hit_yes, hit_no}
  task automatic drive(input logic [4:0] in);
    {dialog_req, dialog_cancel, touch_valid, hit_yes, hit_no} = in;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs();
    return {dbg_state, det_enable, dialog_active, answer_valid, answer_yes, answer_timeout};
  endfunction

  // ---------------- vector table ----------------
  // out = {det_enable, dialog_active, answer_valid, answer_yes, answer_timeout}
  typedef struct packed {
    logic [4:0]    in;
    dialog_state_t st;
    logic [4:0]    out;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [4:0] in, input dialog_state_t st,
                              input logic [4:0] out, input int n = 1);
    for (int k = 0; k < n; k++) vecs.push_back('{in: in, st: st, out: out});
  endfunction

  initial begin
    // Normal YES, answer one cycle after release
    add(5'b10000, S_ARM,          5'b11000);
    add(5'b00000, S_WAIT_PRESS,   5'b11000);
    add(5'b00110, S_HOLD,         5'b11000, 3);
    add(5'b00110, S_WAIT_RELEASE, 5'b11000, 2);
    add(5'b00000, S_DONE,         5'b01110);
    add(5'b00000, S_IDLE,         5'b00010);
    // Slide YES -> NO: hold restarts on NO, result is NO
    add(5'b10000, S_ARM,          5'b11010);
    add(5'b00000, S_WAIT_PRESS,   5'b11010);
    add(5'b00110, S_HOLD,         5'b11010, 3);
    add(5'b00101, S_WAIT_PRESS,   5'b11010);
    add(5'b00101, S_HOLD,         5'b11010, 3);
    add(5'b00101, S_WAIT_RELEASE, 5'b11010);
    add(5'b00000, S_DONE,         5'b01100);
    add(5'b00000, S_IDLE,         5'b00000);
    // Carry-over press holds ARM, then a short bounce, then a full NO press
    add(5'b10110, S_ARM,          5'b11000);
    add(5'b00110, S_ARM,          5'b11000, 2);
    add(5'b00000, S_WAIT_PRESS,   5'b11000);
    add(5'b00101, S_HOLD,         5'b11000, 2);
    add(5'b00000, S_WAIT_PRESS,   5'b11000);
    add(5'b00101, S_HOLD,         5'b11000, 3);
    add(5'b00101, S_WAIT_RELEASE, 5'b11000);
    add(5'b00000, S_DONE,         5'b01100);
    add(5'b00000, S_IDLE,         5'b00000);
    // Both boxes lit never starts a hold; cancel closes without an answer
    add(5'b10000, S_ARM,          5'b11000);
    add(5'b00000, S_WAIT_PRESS,   5'b11000);
    add(5'b00111, S_WAIT_PRESS,   5'b11000, 10);
    add(5'b01000, S_IDLE,         5'b00000);
    // hit_yes only during the first enabled cycle is ignored
    add(5'b10000, S_ARM,          5'b11000);
    add(5'b00010, S_WAIT_PRESS,   5'b11000);
    add(5'b00000, S_WAIT_PRESS,   5'b11000, 2);
    add(5'b01000, S_IDLE,         5'b00000);
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int seen;
    int cnt2;
    drive(5'b00000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {24'd0, obs()}, {24'd0, S_IDLE, 5'b00000});
    check("reset_state_nt", {dbg_state2, answer_valid2, dialog_active2}, {S_IDLE, 2'b00});
    reset = 1'b1;
    tick();
    check("idle_after_reset", {24'd0, obs()}, {24'd0, S_IDLE, 5'b00000});

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      tick();
      check($sformatf("vec%0d", i), {24'd0, obs()}, {24'd0, vecs[i].st, vecs[i].out});
    end

    // Timeout: req sampled at edge 0, answer after edge TOUT, i.e. 21 cycles after the req cycle
    drive(5'b10000);
    tick();
    drive(5'b00000);
    n = 0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick();
      n++;
      if (answer_valid) seen = 1;
    end
    check("timeout_seen", seen, 1);
    check("timeout_latency", n, 20);
    check("timeout_flags", {answer_yes, answer_timeout, dialog_active, det_enable}, 4'b0110);
    tick();
    check("timeout_close", {24'd0, obs()}, {24'd0, S_IDLE, 5'b00001});

    // Cancel during HOLD keeps previous results
    drive(5'b10000); tick();
    drive(5'b00000); tick();
    drive(5'b00110); tick(); tick();
    check("cancel_pre_hold", dbg_state, S_HOLD);
    drive(5'b01110); tick();
    check("cancel_idle", {24'd0, obs()}, {24'd0, S_IDLE, 5'b00001});
    drive(5'b00000);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (answer_valid) seen++;
    end
    check("cancel_no_answer", seen, 0);

    // Async reset while in WAIT_RELEASE
    drive(5'b10000); tick();
    drive(5'b00000); tick();
    drive(5'b00110);
    repeat (4) tick();
    check("wr_before_reset", {24'd0, obs()}, {24'd0, S_WAIT_RELEASE, 5'b11001});
    #2 reset = 1'b0;
    #1;
    check("async_reset", {24'd0, obs()}, {24'd0, S_IDLE, 5'b00000});
    drive(5'b00000);
    tick(); tick();
    reset = 1'b1;
    tick();

    // TIMEOUT_CYCLES=0: dialog stays open indefinitely
    req2 = 1'b1; tick();
    req2 = 1'b0;
    cnt2 = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (answer_valid2) cnt2++;
    end
    check("no_timeout_answers", cnt2, 0);
    check("no_timeout_active", {dialog_active2, det_enable2}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
